// File: rtl/status_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : status_reg_if
// Description : Status-register port bundle. The control unit and ALU sit on
//               the master side and the status register on the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface status_reg_if;

  // Update requests from ALU / control unit
  logic [7:0] st_alu;     // ALU st_out flag vector
  logic       alu_we;     // load st_alu into SREG
  logic [2:0] bit_sel;    // flag index for set/clear
  logic       bit_set;    // set SREG[bit_sel]
  logic       bit_clr;    // clear SREG[bit_sel]
  logic       int_entry;  // interrupt accepted: push, clear I
  logic       int_ret;    // return from interrupt: pop, set I

  // Branch condition query
  logic [2:0] cond_sel;   // flag index tested
  logic       cond_val;   // required flag value

  // Status register responses
  logic [7:0] sreg;       // current flags, feeds ALU st_in
  logic       cond_true;  // sreg[cond_sel] == cond_val
  logic [1:0] depth;      // shadow stack occupancy 0..2
  logic       ovf;        // sticky push-at-full
  logic       unf;        // sticky pop-at-empty

  modport master (
    output st_alu, alu_we, bit_sel, bit_set, bit_clr, int_entry, int_ret,
    output cond_sel, cond_val,
    input  sreg, cond_true, depth, ovf, unf
  );

  modport slave (
    input  st_alu, alu_we, bit_sel, bit_set, bit_clr, int_entry, int_ret,
    input  cond_sel, cond_val,
    output sreg, cond_true, depth, ovf, unf
  );

endinterface
`default_nettype wire

// File: rtl/status_reg.sv
`default_nettype none
// ============================================================================
// Module      : status_reg
// Description : Processor status register (SREG). Captures ALU flags, runs
//               flag set/clear, saves/restores flags across interrupts via a
//               two-deep shadow stack and evaluates branch conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module status_reg (
  input  logic          clk,
  input  logic          reset,
  status_reg_if.slave   bus
);

  // Position of the global interrupt-enable flag within SREG
  localparam int unsigned c_IF = 7;

  localparam logic [1:0] c_DEPTH_EMPTY = 2'd0;
  localparam logic [1:0] c_DEPTH_ONE   = 2'd1;
  localparam logic [1:0] c_DEPTH_FULL  = 2'd2;

  logic [7:0] r_sreg;
  logic [7:0] r_sh0;     // bottom shadow entry
  logic [7:0] r_sh1;     // top shadow entry when two are stacked
  logic [1:0] r_depth;
  logic       r_ovf;
  logic       r_unf;

  logic [7:0] w_top;

  // Entry that a return would restore: sh1 when two are stacked, else sh0
  assign w_top = (r_depth == c_DEPTH_FULL) ? r_sh1 : r_sh0;

  // Single update source per cycle, fixed priority:
  // int_entry > int_ret > bit_set/bit_clr > alu_we
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sreg  <= 8'h00;
      r_sh0   <= 8'h00;
      r_sh1   <= 8'h00;
      r_depth <= c_DEPTH_EMPTY;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (bus.int_entry) begin
      // Save pre-edge flags; a full stack keeps its contents and flags ovf
      if (r_depth == c_DEPTH_EMPTY) begin
        r_sh0   <= r_sreg;
        r_depth <= c_DEPTH_ONE;
      end else if (r_depth == c_DEPTH_ONE) begin
        r_sh1   <= r_sreg;
        r_depth <= c_DEPTH_FULL;
      end else begin
        r_ovf   <= 1'b1;
      end
      r_sreg[c_IF] <= 1'b0;
    end else if (bus.int_ret) begin
      // Restore saved flags with interrupts re-enabled; empty pop flags unf
      if (r_depth == c_DEPTH_EMPTY) begin
        r_unf <= 1'b1;
      end else begin
        r_sreg       <= w_top;
        r_sreg[c_IF] <= 1'b1;
        r_depth      <= r_depth - 2'd1;
      end
    end else if (bus.bit_clr) begin
      // Clear takes precedence when set and clear arrive together
      r_sreg[bus.bit_sel] <= 1'b0;
    end else if (bus.bit_set) begin
      r_sreg[bus.bit_sel] <= 1'b1;
    end else if (bus.alu_we) begin
      r_sreg <= bus.st_alu;
    end
  end

  assign bus.sreg      = r_sreg;
  assign bus.depth     = r_depth;
  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;
  // Branch test looks only at the registered flags
  assign bus.cond_true = (r_sreg[bus.cond_sel] == bus.cond_val);

endmodule
`default_nettype wire

// File: tb/tb_status_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_reg
// Description : Self-checking bench for status_reg. A reference model computes
//               the expected state for each driven cycle and queues it; the
//               queued entry is compared once the DUT has taken the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_reg;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  status_reg_if bus ();

  status_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] sreg;
    logic [1:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_sreg, m_sh0, m_sh1;
  logic [1:0] m_depth;
  logic       m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sreg = 8'h00; m_sh0 = 8'h00; m_sh1 = 8'h00;
    m_depth = 2'd0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic idle();
    bus.st_alu = 8'h00; bus.alu_we = 1'b0;
    bus.bit_sel = 3'd0; bus.bit_set = 1'b0; bus.bit_clr = 1'b0;
    bus.int_entry = 1'b0; bus.int_ret = 1'b0;
  endtask

  // Drive one cycle of requests, predict, take the edge, compare
  task automatic step(input logic [7:0] st, input logic we, input logic [2:0] bsel,
                      input logic bset, input logic bclr, input logic ient, input logic iret);
    exp_t e;
    exp_t got;
    bus.st_alu = st; bus.alu_we = we; bus.bit_sel = bsel;
    bus.bit_set = bset; bus.bit_clr = bclr;
    bus.int_entry = ient; bus.int_ret = iret;
    if (ient) begin
      if (m_depth == 2'd0) m_sh0 = m_sreg;
      else if (m_depth == 2'd1) m_sh1 = m_sreg;
      if (m_depth < 2'd2) m_depth = m_depth + 2'd1;
      else m_ovf = 1'b1;
      m_sreg[7] = 1'b0;
    end else if (iret) begin
      if (m_depth == 2'd0) m_unf = 1'b1;
      else begin
        m_sreg  = ((m_depth == 2'd2) ? m_sh1 : m_sh0) | 8'h80;
        m_depth = m_depth - 2'd1;
      end
    end else if (bclr) m_sreg[bsel] = 1'b0;
    else if (bset)     m_sreg[bsel] = 1'b1;
    else if (we)       m_sreg = st;
    e.sreg = m_sreg; e.depth = m_depth; e.ovf = m_ovf; e.unf = m_unf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    idle();
    got = sb_q.pop_front();
    check("sreg",  {24'd0, bus.sreg},  {24'd0, got.sreg});
    check("depth", {30'd0, bus.depth}, {30'd0, got.depth});
    check("ovf",   {31'd0, bus.ovf},   {31'd0, got.ovf});
    check("unf",   {31'd0, bus.unf},   {31'd0, got.unf});
    check("cond_true", {31'd0, bus.cond_true},
          {31'd0, (got.sreg[bus.cond_sel] == bus.cond_val)});
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.cond_sel = 3'd0;
    bus.cond_val = 1'b0;
    model_reset();
    #12;
    // Reset state
    check("rst_sreg",  {24'd0, bus.sreg},  32'h00);
    check("rst_depth", {30'd0, bus.depth}, 32'h0);
    check("rst_ovf",   {31'd0, bus.ovf},   32'h0);
    check("rst_unf",   {31'd0, bus.unf},   32'h0);
    check("rst_cond_v0", {31'd0, bus.cond_true}, 32'h1);
    bus.cond_val = 1'b1;
    #1;
    check("rst_cond_v1", {31'd0, bus.cond_true}, 32'h0);
    reset = 1'b0;

    // ALU load, branch on C
    step(8'h83, 1, 0, 0, 0, 0, 0);
    check("alu_83", {24'd0, bus.sreg}, 32'h83);
    check("cond_c", {31'd0, bus.cond_true}, 32'h1);

    // Set/clear, clear wins
    step(8'h80, 1, 0, 0, 0, 0, 0);
    step(8'h00, 0, 1, 1, 1, 0, 0);
    check("clr_wins", {24'd0, bus.sreg}, 32'h80);
    step(8'h00, 0, 1, 1, 0, 0, 0);
    check("set_z", {24'd0, bus.sreg}, 32'h82);

    // Interrupt nesting, overflow, underflow
    step(8'h85, 1, 0, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0, 1, 0);
    check("ent1_sreg",  {24'd0, bus.sreg},  32'h05);
    check("ent1_depth", {30'd0, bus.depth}, 32'h1);
    step(8'h83, 1, 0, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0, 1, 0);
    check("ent2_sreg",  {24'd0, bus.sreg},  32'h03);
    check("ent2_depth", {30'd0, bus.depth}, 32'h2);
    step(8'h00, 0, 0, 0, 0, 1, 0);
    check("ent3_ovf",   {31'd0, bus.ovf},   32'h1);
    check("ent3_depth", {30'd0, bus.depth}, 32'h2);
    step(8'h00, 0, 0, 0, 0, 0, 1);
    check("ret1_sreg",  {24'd0, bus.sreg},  32'h83);
    step(8'h00, 0, 0, 0, 0, 0, 1);
    check("ret2_sreg",  {24'd0, bus.sreg},  32'h85);
    check("ret2_depth", {30'd0, bus.depth}, 32'h0);
    step(8'h00, 0, 0, 0, 0, 0, 1);
    check("ret3_unf",   {31'd0, bus.unf},   32'h1);
    check("ret3_sreg",  {24'd0, bus.sreg},  32'h85);

    // int_entry beats a simultaneous ALU write
    step(8'h81, 1, 0, 0, 0, 0, 0);
    step(8'hFF, 1, 0, 0, 0, 1, 0);
    check("ent_drop_alu", {24'd0, bus.sreg}, 32'h01);
    step(8'h00, 0, 0, 0, 0, 0, 1);
    check("sh0_81", {24'd0, bus.sreg}, 32'h81);

    // Back-to-back ALU writes
    step(8'h11, 1, 0, 0, 0, 0, 0);
    step(8'h22, 1, 0, 0, 0, 0, 0);
    step(8'h44, 1, 0, 0, 0, 0, 0);
    check("b2b_alu", {24'd0, bus.sreg}, 32'h44);

    // Random mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] st;
      st = 8'($urandom_range(0, 255));
      bus.cond_sel = 3'($urandom_range(0, 7));
      bus.cond_val = 1'($urandom_range(0, 1));
      step(st, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset at full depth with both sticky flags set
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
    step(8'h00, 0, 0, 0, 0, 0, 1);
    step(8'hF0, 1, 0, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0, 1, 0);
    step(8'h00, 0, 0, 0, 0, 1, 0);
    step(8'h00, 0, 0, 0, 0, 1, 0);
    check("pre_rst_ovf",   {31'd0, bus.ovf},   32'h1);
    check("pre_rst_unf",   {31'd0, bus.unf},   32'h1);
    check("pre_rst_depth", {30'd0, bus.depth}, 32'h2);
    #3;
    reset = 1'b1;
    #1;
    check("arst_sreg",  {24'd0, bus.sreg},  32'h00);
    check("arst_depth", {30'd0, bus.depth}, 32'h0);
    check("arst_ovf",   {31'd0, bus.ovf},   32'h0);
    check("arst_unf",   {31'd0, bus.unf},   32'h0);
    #10;
    reset = 1'b0;
    model_reset();
    step(8'h00, 0, 0, 0, 0, 0, 1);
    check("post_rst_sreg", {24'd0, bus.sreg}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
